// File: rtl/ir_pkg.sv
// Shared IR protocol definitions: FSM encodings, command bit positions and nominal timings.
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAR_SEL = 2'b01,
        BITS    = 2'b11
    } ir_state_e;

    localparam int unsigned CMD_RIGHT    = 0;
    localparam int unsigned CMD_LEFT     = 1;
    localparam int unsigned CMD_BACKWARD = 2;
    localparam int unsigned CMD_FORWARD  = 3;

    localparam int unsigned DEF_START_BURST_SIZE      = 88;
    localparam int unsigned DEF_CAR_SELECT_BURST_SIZE = 22;
    localparam int unsigned DEF_GAP_SIZE              = 40;
    localparam int unsigned DEF_ASSERT_BURST_SIZE     = 44;
    localparam int unsigned DEF_DEASSERT_BURST_SIZE   = 22;
    localparam int unsigned DEF_TOLERANCE             = 8;
    localparam int unsigned DEF_COUNTER_WIDTH         = 12;

    // Inclusive window test written without subtraction so small n cannot underflow.
    function automatic logic in_window(input int unsigned run,
                                       input int unsigned n,
                                       input int unsigned tol);
        return ((run + tol) >= n) && (run <= (n + tol));
    endfunction

endpackage

// File: rtl/ir_receiver_sm_if.sv
// IR receiver pin-side and command-side signal bundle.
interface ir_receiver_sm_if;
    logic       IR_IN;
    logic [3:0] COMMAND;
    logic       PACKET_VALID;
    logic       PACKET_ERR;

    modport master (input IR_IN, output COMMAND, PACKET_VALID, PACKET_ERR);
    modport slave  (output IR_IN, input COMMAND, PACKET_VALID, PACKET_ERR);
endinterface

// File: rtl/ir_run_length.sv
// Synchronises the IR envelope, detects edges and measures the current run length.
module ir_run_length #(
    parameter int unsigned COUNTER_WIDTH = 12
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_ir,
    output logic                     o_rise_c,
    output logic                     o_fall_c,
    output logic                     o_ir_d,
    output logic [COUNTER_WIDTH-1:0] o_run
);

    logic                     r_sync1;
    logic                     r_ir_s;
    logic                     r_ir_d;
    logic [COUNTER_WIDTH-1:0] r_run;

    // The edge cycle itself is the first cycle of the new run, so the count restarts at 1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_ir_s  <= 1'b0;
            r_ir_d  <= 1'b0;
            r_run   <= '0;
        end else begin
            r_sync1 <= i_ir;
            r_ir_s  <= r_sync1;
            r_ir_d  <= r_ir_s;
            if (r_ir_s != r_ir_d)
                r_run <= COUNTER_WIDTH'(1);
            else if (r_run != '1)
                r_run <= r_run + COUNTER_WIDTH'(1);
        end
    end

    assign o_rise_c = r_ir_s & ~r_ir_d;
    assign o_fall_c = ~r_ir_s & r_ir_d;
    assign o_ir_d   = r_ir_d;
    assign o_run    = r_run;

endmodule

// File: rtl/ir_receiver_sm.sv
// IR command receiver: classifies burst/gap lengths and assembles a 4-bit command.
module ir_receiver_sm
    import ir_pkg::*;
#(
    parameter int unsigned START_BURST_SIZE      = DEF_START_BURST_SIZE,
    parameter int unsigned CAR_SELECT_BURST_SIZE = DEF_CAR_SELECT_BURST_SIZE,
    parameter int unsigned GAP_SIZE              = DEF_GAP_SIZE,
    parameter int unsigned ASSERT_BURST_SIZE     = DEF_ASSERT_BURST_SIZE,
    parameter int unsigned DEASSERT_BURST_SIZE   = DEF_DEASSERT_BURST_SIZE,
    parameter int unsigned TOLERANCE             = DEF_TOLERANCE,
    parameter int unsigned COUNTER_WIDTH         = DEF_COUNTER_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    ir_receiver_sm_if.master bus
);

    localparam int unsigned TIMEOUT_RUN = GAP_SIZE + TOLERANCE + 1;

    logic                     w_rise;
    logic                     w_fall;
    logic                     w_ir_d;
    logic [COUNTER_WIDTH-1:0] w_run;

    ir_run_length #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_run_length (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_ir     (bus.IR_IN),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall),
        .o_ir_d   (w_ir_d),
        .o_run    (w_run)
    );

    ir_state_e r_state, w_state_nx;
    logic [1:0] r_idx, w_idx_nx;
    logic [3:0] r_shift, w_shift_nx;
    logic [3:0] r_command, w_command_nx;
    logic       r_valid, w_valid_nx;
    logic       r_err, w_err_nx;

    int unsigned w_run32;
    logic        w_timeout;
    logic        w_gap_short;
    logic        w_bit_one;
    logic        w_bit_zero;

    assign w_run32     = 32'(w_run);
    assign w_timeout   = ~w_ir_d && (w_run32 >= TIMEOUT_RUN);
    assign w_gap_short = w_rise && ((w_run32 + TOLERANCE) < GAP_SIZE);
    assign w_bit_one   = in_window(w_run32, ASSERT_BURST_SIZE, TOLERANCE);
    assign w_bit_zero  = in_window(w_run32, DEASSERT_BURST_SIZE, TOLERANCE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_shift   <= '0;
            r_command <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_shift   <= w_shift_nx;
            r_command <= w_command_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
        end
    end

    // Gap timeout and short-gap checks share priority ahead of burst classification.
    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_command_nx = r_command;
        w_valid_nx   = 1'b0;
        w_err_nx     = 1'b0;
        case (r_state)
            IDLE: begin
                w_idx_nx   = '0;
                w_shift_nx = '0;
                if (w_fall && in_window(w_run32, START_BURST_SIZE, TOLERANCE))
                    w_state_nx = CAR_SEL;
            end
            CAR_SEL: begin
                if (w_timeout || w_gap_short) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_fall) begin
                    if (in_window(w_run32, CAR_SELECT_BURST_SIZE, TOLERANCE)) begin
                        w_state_nx = BITS;
                        w_idx_nx   = '0;
                        w_shift_nx = '0;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
            end
            BITS: begin
                if (w_timeout || w_gap_short) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_fall) begin
                    if (w_bit_one || w_bit_zero) begin
                        w_shift_nx[r_idx] = w_bit_one;
                        w_idx_nx          = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_command_nx = w_shift_nx;
                            w_valid_nx   = 1'b1;
                            w_state_nx   = IDLE;
                        end
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.COMMAND      = r_command;
    assign bus.PACKET_VALID = r_valid;
    assign bus.PACKET_ERR   = r_err;

endmodule

// File: tb/tb_ir_receiver_sm.sv
// Directed bench for ir_receiver_sm: packet table plus timeout, glitch, reset and back-to-back sequences.
module tb_ir_receiver_sm;
    import ir_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ir_receiver_sm_if bus ();

    ir_receiver_sm dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         start_len;
        int         car_len;
        int         gap_len;
        int         b0, b1, b2, b3;
        int         exp_valid;
        int         exp_err;
        logic [3:0] exp_cmd;
    } vec_t;

    vec_t tbl[16];

    int         valid_cnt;
    int         err_cnt;
    int         overlap_cnt;
    int         long_pulse_cnt;
    logic       prev_valid;
    logic       prev_err;
    logic [3:0] cmd_q[$];

    // Strobe bookkeeping sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_err   <= 1'b0;
        end else begin
            if (bus.PACKET_VALID) begin
                valid_cnt <= valid_cnt + 1;
                cmd_q.push_back(bus.COMMAND);
            end
            if (bus.PACKET_ERR) err_cnt <= err_cnt + 1;
            if (bus.PACKET_VALID && bus.PACKET_ERR) overlap_cnt <= overlap_cnt + 1;
            if ((bus.PACKET_VALID && prev_valid) || (bus.PACKET_ERR && prev_err))
                long_pulse_cnt <= long_pulse_cnt + 1;
            prev_valid <= bus.PACKET_VALID;
            prev_err   <= bus.PACKET_ERR;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hi(input int n);
        bus.IR_IN = 1'b1;
        repeat (n) @(negedge clk);
        bus.IR_IN = 1'b0;
    endtask

    task automatic lo(input int n);
        bus.IR_IN = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input vec_t v);
        hi(v.start_len); lo(v.gap_len);
        hi(v.car_len);   lo(v.gap_len);
        hi(v.b0);        lo(v.gap_len);
        hi(v.b1);        lo(v.gap_len);
        hi(v.b2);        lo(v.gap_len);
        hi(v.b3);
    endtask

    function automatic vec_t mk(input int s, input int c, input int g,
                                input int b0, input int b1, input int b2, input int b3,
                                input int ev, input int ee, input logic [3:0] cmd);
        vec_t v;
        v.start_len = s; v.car_len = c; v.gap_len = g;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.exp_valid = ev; v.exp_err = ee; v.exp_cmd = cmd;
        return v;
    endfunction

    function automatic vec_t nominal(input logic [3:0] cmd);
        return mk(88, 22, 40, cmd[0] ? 44 : 22, cmd[1] ? 44 : 22,
                  cmd[2] ? 44 : 22, cmd[3] ? 44 : 22, 1, 0, cmd);
    endfunction

    task automatic run_packet(input string name, input vec_t v);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send(v);
        lo(60);
        check({name, " valid"}, valid_cnt - v0, v.exp_valid);
        check({name, " err"}, err_cnt - e0, v.exp_err);
        check({name, " cmd"}, int'(bus.COMMAND), int'(v.exp_cmd));
    endtask

    initial begin
        int v0, e0, qb, err_at;
        checks = 0; errors = 0;
        valid_cnt = 0; err_cnt = 0; overlap_cnt = 0; long_pulse_cnt = 0;
        prev_valid = 1'b0; prev_err = 1'b0;

        tbl[0]  = mk(88, 22, 40, 22, 44, 22, 44, 1, 0, 4'b1010);
        tbl[1]  = mk(88, 22, 40, 35, 44, 22, 44, 0, 1, 4'b1010);
        tbl[2]  = mk(88, 22, 40, 36, 52, 14, 30, 1, 0, 4'b0011);
        tbl[3]  = mk(80, 14, 40, 22, 22, 22, 44, 1, 0, 4'b1000);
        tbl[4]  = mk(96, 30, 40, 44, 22, 44, 22, 1, 0, 4'b0101);
        tbl[5]  = mk(79, 22, 40, 44, 44, 44, 44, 0, 0, 4'b0101);
        tbl[6]  = mk(97, 22, 40, 44, 44, 44, 44, 0, 0, 4'b0101);
        tbl[7]  = mk(88, 13, 40, 44, 44, 44, 44, 0, 1, 4'b0101);
        tbl[8]  = mk(88, 31, 40, 44, 44, 44, 44, 0, 1, 4'b0101);
        tbl[9]  = mk(88, 22, 40, 44, 44, 53, 22, 0, 1, 4'b0101);
        tbl[10] = mk(88, 22, 40, 22, 31, 22, 22, 0, 1, 4'b0101);
        tbl[11] = mk(88, 22, 40, 22, 13, 22, 22, 0, 1, 4'b0101);
        tbl[12] = mk(88, 22, 32, 44, 44, 44, 44, 1, 0, 4'b1111);
        tbl[13] = mk(88, 22, 48, 22, 44, 44, 22, 1, 0, 4'b0110);
        tbl[14] = mk(88, 22, 31, 44, 44, 44, 44, 0, 1, 4'b0110);
        tbl[15] = mk(88, 22, 49, 44, 44, 44, 44, 0, 1, 4'b0110);

        rst = 1'b1;
        bus.IR_IN = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd", int'(bus.COMMAND), 0);
        check("reset valid", int'(bus.PACKET_VALID), 0);
        check("reset err", int'(bus.PACKET_ERR), 0);
        rst = 1'b0;
        lo(20);

        for (int i = 0; i < 16; i++)
            run_packet($sformatf("vec%0d", i), tbl[i]);

        // Gap timeout after the car-select burst.
        e0 = err_cnt;
        hi(88); lo(40); hi(22);
        err_at = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.PACKET_ERR && err_at == 0) err_at = i;
        end
        check("timeout err cycle", err_at, 52);
        check("timeout err count", err_cnt - e0, 1);
        check("timeout state", int'(dut.r_state), int'(IDLE));
        run_packet("after timeout", nominal(4'b0101));

        // Short glitch while idle is noise.
        v0 = valid_cnt; e0 = err_cnt;
        hi(10); lo(60);
        check("glitch valid", valid_cnt - v0, 0);
        check("glitch err", err_cnt - e0, 0);
        run_packet("after glitch", nominal(4'b1111));

        // Reset asserted in the middle of bit 2.
        e0 = err_cnt;
        hi(88); lo(40); hi(22); lo(40);
        hi(44); lo(40); hi(22); lo(40);
        bus.IR_IN = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset cmd", int'(bus.COMMAND), 0);
        check("midreset valid", int'(bus.PACKET_VALID), 0);
        check("midreset err", int'(bus.PACKET_ERR), 0);
        check("midreset state", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
        lo(60);
        check("midreset no err", err_cnt - e0, 0);
        run_packet("after reset", nominal(4'b0001));

        // Back-to-back packets with only a nominal gap between them.
        v0 = valid_cnt; e0 = err_cnt; qb = cmd_q.size();
        send(nominal(4'b1000));
        lo(40);
        send(nominal(4'b0110));
        lo(60);
        check("b2b valid", valid_cnt - v0, 2);
        check("b2b err", err_cnt - e0, 0);
        check("b2b queue", cmd_q.size() - qb, 2);
        if (cmd_q.size() >= qb + 2) begin
            check("b2b cmd0", int'(cmd_q[qb]), int'(4'b1000));
            check("b2b cmd1", int'(cmd_q[qb + 1]), int'(4'b0110));
        end

        check("valid/err overlap", overlap_cnt, 0);
        check("strobe width", long_pulse_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
